// File: rtl/adc_sample_scheduler.sv
// Time-division scheduler for a shared MCP3008 SPI engine: fixed-rate audio
// conversions with round-robin pot conversions fitted into the idle gaps.
module adc_pot_slot #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic         vld
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout <= '0;
      vld  <= 1'b0;
    end else begin
      vld <= wr;
      if (wr) dout <= din;
    end
  end
endmodule

module adc_sample_scheduler #(
  parameter int N            = 10,
  parameter int CHANNELS     = 2,
  parameter int AUD_CH       = 0,
  parameter int POT_BASE     = 1,
  parameter int TICK_DIV     = 833,
  parameter int POT_DIV      = 64,
  parameter int CONV_TIMEOUT = 2047
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic                  conv_start,
  output logic [2:0]            conv_ch,
  input  logic                  conv_busy,
  input  logic                  conv_done,
  input  logic [N-1:0]          conv_data,
  output logic [N-1:0]          audio_out,
  output logic                  audio_valid,
  output logic [CHANNELS*N-1:0] pot_out,
  output logic [CHANNELS-1:0]   pot_valid,
  output logic                  overrun,
  output logic                  timeout_err,
  input  logic                  clr_err
);
  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PDW = (POT_DIV > 1) ? $clog2(POT_DIV) : 1;
  localparam int PW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int WW  = $clog2(CONV_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, nxt;

  logic [TW-1:0]  tcnt;
  logic [PDW-1:0] pcnt;
  logic [PW-1:0]  ptr;
  logic [WW-1:0]  wcnt;
  logic audio_pend, pot_pend, cur_is_audio;
  logic go, done_hit, to_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt        = state;
    conv_start = 1'b0;
    go         = 1'b0;
    done_hit   = 1'b0;
    to_hit     = 1'b0;
    case (state)
      IDLE: if (enable && !conv_busy && (audio_pend || pot_pend)) begin
        nxt = ISSUE;
        go  = 1'b1;
      end
      ISSUE: begin
        conv_start = 1'b1;
        nxt        = WAIT;
      end
      WAIT: if (conv_done) begin
        done_hit = 1'b1;
        nxt      = IDLE;
      end else if (wcnt == WW'(CONV_TIMEOUT - 1)) begin
        to_hit = 1'b1;
        nxt    = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  logic tick, aud_clr, pot_clr, aud_done, pot_done, pot_wrap, ovr_evt;
  assign tick     = enable && (tcnt == TW'(TICK_DIV - 1));
  assign aud_clr  = (state == ISSUE) && cur_is_audio;
  assign pot_clr  = (state == ISSUE) && !cur_is_audio;
  assign aud_done = done_hit && cur_is_audio;
  assign pot_done = done_hit && !cur_is_audio;
  assign pot_wrap = aud_done && (pcnt == PDW'(POT_DIV - 1));
  // The sample being issued this cycle is not a missed one.
  assign ovr_evt  = tick && audio_pend && !aud_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt         <= '0;
      pcnt         <= '0;
      ptr          <= '0;
      wcnt         <= '0;
      audio_pend   <= 1'b0;
      pot_pend     <= 1'b0;
      cur_is_audio <= 1'b0;
      conv_ch      <= '0;
      audio_out    <= '0;
      audio_valid  <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (!enable || tick) tcnt <= '0;
      else                 tcnt <= tcnt + 1'b1;

      if (!enable)      audio_pend <= 1'b0;
      else if (tick)    audio_pend <= 1'b1;
      else if (aud_clr) audio_pend <= 1'b0;

      if (!enable)       pot_pend <= 1'b0;
      else if (pot_wrap) pot_pend <= 1'b1;
      else if (pot_clr)  pot_pend <= 1'b0;

      if (pot_wrap)      pcnt <= '0;
      else if (aud_done) pcnt <= pcnt + 1'b1;

      wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;

      if (go) begin
        cur_is_audio <= audio_pend;
        conv_ch      <= audio_pend ? 3'(AUD_CH) : 3'(POT_BASE) + 3'(ptr);
      end

      if (pot_done) ptr <= (ptr == PW'(CHANNELS - 1)) ? '0 : ptr + 1'b1;

      audio_valid <= aud_done;
      if (aud_done) audio_out <= conv_data;

      if (ovr_evt)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;

      if (to_hit)       timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

  logic [CHANNELS-1:0][N-1:0] pot_q;
  assign pot_out = pot_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pot
    adc_pot_slot #(.N(N)) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .wr      (pot_done && (ptr == PW'(g))),
      .din     (conv_data),
      .dout    (pot_q[g]),
      .vld     (pot_valid[g])
    );
  end
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler with a behavioural SPI engine model.
module tb_adc_sample_scheduler;
  localparam int N = 10, CH = 2, TICK = 833, PDIV = 4, TMO = 100, LAT = 30;

  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, clr_err = 1'b0;
  logic conv_start, conv_busy = 1'b0, conv_done = 1'b0;
  logic [2:0] conv_ch;
  logic [N-1:0] conv_data = '0, audio_out;
  logic audio_valid, overrun, timeout_err;
  logic [CH*N-1:0] pot_out;
  logic [CH-1:0] pot_valid;

  adc_sample_scheduler #(.N(N), .CHANNELS(CH), .AUD_CH(0), .POT_BASE(1),
    .TICK_DIV(TICK), .POT_DIV(PDIV), .CONV_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .conv_start(conv_start),
    .conv_ch(conv_ch), .conv_busy(conv_busy), .conv_done(conv_done),
    .conv_data(conv_data), .audio_out(audio_out), .audio_valid(audio_valid),
    .pot_out(pot_out), .pot_valid(pot_valid), .overrun(overrun),
    .timeout_err(timeout_err), .clr_err(clr_err));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_start = 0, n_aval = 0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (conv_start) n_start = n_start + 1;
    if (audio_valid) n_aval = n_aval + 1;
  end

  // SPI engine model: done LAT cycles after the start pulse.
  logic respond = 1'b1, force_busy = 1'b0, hold_on_done = 1'b0;
  logic [N-1:0] aud_data = 10'h2A5;
  int m_cnt = 0, done_cyc = 0;
  logic [2:0] m_ch = '0;
  always @(negedge clk) begin
    conv_done = 1'b0;
    if (m_cnt != 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0 && respond) begin
        conv_done = 1'b1;
        done_cyc  = cyc;
        conv_data = (m_ch == 3'd0) ? aud_data : ((m_ch == 3'd1) ? 10'h100 : 10'h200);
        if (hold_on_done) force_busy = 1'b1;
      end
    end else if (conv_start) begin
      m_cnt = LAT;
      m_ch  = conv_ch;
    end
    conv_busy = force_busy || (m_cnt != 0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cond(input int which);
    case (which)
      0: return conv_start;
      1: return audio_valid;
      2: return |pot_valid;
      3: return overrun;
      default: return timeout_err;
    endcase
  endfunction

  task automatic wait_for(input int which, input int bound, input string tag);
    int n = 0;
    @(negedge clk);
    while (!cond(which) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!cond(which)) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] all_out();
    return 64'({conv_start, conv_ch, audio_out, audio_valid, pot_out, pot_valid,
                overrun, timeout_err});
  endfunction

  int c0, s, prev_a, x, snap;
  int exp_ch[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", all_out(), 64'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    c0      = cyc;
    prev_a  = -1;

    // Audio path and pot round-robin over the first ten conversions.
    for (int i = 0; i < 10; i++) begin
      wait_for(0, 1000, "start");
      s = cyc;
      check($sformatf("ch_seq%0d", i), conv_ch, exp_ch[i]);
      if (i == 0) check("first_start_cyc", s - c0, 834);
      if (exp_ch[i] == 0) begin
        if (prev_a >= 0) check($sformatf("aud_period%0d", i), s - prev_a, TICK);
        prev_a = s;
        wait_for(1, 100, "aud_valid");
        check("audio_out", audio_out, 10'h2A5);
        if (i == 0) begin
          check("aval_after_done", cyc - done_cyc, 1);
          check("aval_after_start", cyc - s, LAT + 1);
        end
      end else begin
        wait_for(2, 100, "pot_valid");
        if (exp_ch[i] == 1) begin
          check("pot_valid0", pot_valid, 2'b01);
          check("pot_out0", pot_out[N-1:0], 10'h100);
        end else begin
          check("pot_valid1", pot_valid, 2'b10);
          check("pot_out_both", pot_out, {10'h200, 10'h100});
        end
      end
    end
    check("no_overrun", overrun, 1'b0);

    // Priority collision: pot and audio both pending while the engine is busy.
    for (int k = 0; k < 4; k++) begin
      wait_for(0, 1000, "start_pre");
      check("pre_coll_ch", conv_ch, 3'd0);
      if (k == 3) hold_on_done = 1'b1;
      wait_for(1, 100, "aud_valid_pre");
    end
    snap = n_start;
    repeat (840) @(negedge clk);
    check("no_issue_busy", n_start, snap);
    hold_on_done = 1'b0;
    force_busy   = 1'b0;
    wait_for(0, 20, "prio_start1");
    check("prio_audio_first", conv_ch, 3'd0);
    wait_for(1, 100, "prio_aval");
    wait_for(0, 20, "prio_start2");
    check("prio_pot_second", conv_ch, 3'd1);
    wait_for(2, 100, "prio_pval");
    check("prio_pot_valid", pot_valid, 2'b01);

    // Overrun: engine held busy across two ticks.
    force_busy = 1'b1;
    wait_for(3, 2000, "overrun");
    x = cyc;
    check("overrun_set", overrun, 1'b1);
    check("no_timeout_yet", timeout_err, 1'b0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("overrun_cleared", overrun, 1'b0);
    while (cyc < x + TICK - 1) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("overrun_beats_clr", overrun, 1'b1);

    // Timeout: engine never answers.
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("errs_cleared", {overrun, timeout_err}, 2'b00);
    respond    = 1'b0;
    force_busy = 1'b0;
    snap       = n_aval;
    wait_for(0, 20, "tmo_start");
    s = cyc;
    wait_for(4, 200, "timeout");
    check("timeout_latency", cyc - s, TMO + 1);
    check("timeout_no_aval", n_aval, snap);
    respond  = 1'b1;
    aud_data = 10'h15A;
    wait_for(0, 1000, "post_tmo_start");
    check("post_tmo_ch", conv_ch, 3'd0);
    wait_for(1, 100, "post_tmo_aval");
    check("post_tmo_audio", audio_out, 10'h15A);
    check("timeout_sticky", timeout_err, 1'b1);

    // Enable drop mid-WAIT: conversion still strobes, nothing new issues.
    aud_data = 10'h0F0;
    wait_for(0, 1000, "en_start");
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_for(1, 100, "en_aval");
    check("en_drop_audio", audio_out, 10'h0F0);
    snap = n_start;
    repeat (1700) @(negedge clk);
    check("en_drop_no_start", n_start, snap);

    // Reset mid-WAIT: outputs clear at once, late conv_done ignored.
    enable   = 1'b1;
    aud_data = 10'h3C3;
    wait_for(0, 1000, "rst_start");
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", all_out(), 64'd0);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    snap = n_aval;
    repeat (40) @(negedge clk);
    check("late_done_no_aval", n_aval, snap);
    check("late_done_audio", audio_out, 10'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_sample_scheduler.md
Name: adc_sample_scheduler

Overview:
- Time-division controller for the single MCP3008 SPI conversion engine, which is shared between the audio input channel and the control-pot channels.
- Issues audio conversions on a fixed sample tick and fits round-robin pot conversions into idle gaps.
- Returns the audio sample with a one-cycle valid strobe for the filter/PWM path, and holds the latest pot values for the filter coefficient logic.
- Sits between the SPI ADC engine and the LPF/HPF processing stage.

Parameters:
- N, 10, ADC/sample width in bits
- CHANNELS, 2, number of pot channels scanned
- AUD_CH, 0, MCP3008 channel index (3 bits) used for audio
- POT_BASE, 1, MCP3008 channel index of pot 0; pot k uses POT_BASE+k
- TICK_DIV, 833, clk cycles per audio sample period (50 MHz / 833 = 60.02 kHz)
- POT_DIV, 64, audio samples between pot conversions
- CONV_TIMEOUT, 2047, maximum WAIT cycles before a conversion is abandoned

Ports:
- clk, in, 1, system clock
- reset_n, in, 1, asynchronous active-low reset
- enable, in, 1, scheduler run enable
- conv_start, out, 1, one-cycle start pulse to the SPI engine
- conv_ch, out, 3, channel select to the SPI engine
- conv_busy, in, 1, SPI engine busy
- conv_done, in, 1, one-cycle pulse; conv_data is valid in this cycle
- conv_data, in, N, conversion result
- audio_out, out, N, latest audio sample
- audio_valid, out, 1, one-cycle strobe: audio_out updated
- pot_out, out, CHANNELS*N, latest pot values; pot k occupies bits [k*N +: N]
- pot_valid, out, CHANNELS, one-cycle per-pot update strobes
- overrun, out, 1, sticky: an audio tick was missed
- timeout_err, out, 1, sticky: a conversion timed out
- clr_err, in, 1, clears overrun and timeout_err

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM in IDLE; tick counter = 0; audio_pend = 0; pot_pend = 0; round-robin pointer = 0; pot sample counter = 0.
- Tick:
  - The counter runs 0..TICK_DIV-1 while enable = 1. tick = 1 in the cycle the counter equals TICK_DIV-1; it then wraps to 0.
  - On tick:
    - If audio_pend = 1, set overrun. audio_pend stays 1, so the missed samples merge into one.
    - Otherwise set audio_pend.
- Pot request:
  - The pot sample counter increments on every audio completion.
  - When it reaches POT_DIV-1, it wraps and sets pot_pend.
- FSM states IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE when enable = 1 and conv_busy = 0 and (audio_pend or pot_pend).
    - Audio has strict priority.
    - The selected kind is latched in cur_is_audio. conv_ch is loaded as AUD_CH or POT_BASE+ptr.
  - ISSUE lasts exactly 1 cycle:
    - conv_start = 1.
    - If the selection is audio, audio_pend is cleared in this cycle; if pot, pot_pend is cleared.
    - Then go to WAIT.
  - conv_ch is held stable from ISSUE through WAIT until the FSM returns to IDLE.
  - WAIT:
    - On conv_done, capture conv_data and return to IDLE.
    - Audio: audio_out <= conv_data, with audio_valid = 1 in the next cycle.
    - Pot: pot_out[ptr] <= conv_data, pot_valid[ptr] = 1 in the next cycle. ptr advances modulo CHANNELS.
    - Total latency is 1 cycle from conv_done to the strobe.
  - WAIT timeout:
    - The wait counter counts cycles in WAIT. When it reaches CONV_TIMEOUT without conv_done, set timeout_err and return to IDLE.
    - No data is captured and no strobe is issued.
    - A timed-out audio conversion is not retried. A timed-out pot conversion does not advance ptr.
- conv_done outside WAIT is ignored.
- A tick in the same cycle as conv_done: both events are handled independently in that cycle.
- clr_err:
  - clr_err = 1 clears both error flags.
  - An error event in the same cycle as clr_err wins: the flag stays set.
- enable = 0:
  - The tick counter is held at 0, and audio_pend and pot_pend are cleared.
  - No new ISSUE is started.
  - A conversion already in WAIT completes or times out normally, including its strobe.
- Asynchronous reset mid-conversion aborts immediately. A conv_done arriving afterwards is ignored (FSM is in IDLE).
- Pot jitter: the system requires TICK_DIV > 2 × (conversion time). With that, a pot conversion started just before a tick delays audio by at most one conversion without causing an overrun.

Test Plan:
- Basic audio path: TICK_DIV=833, model SPI done 30 cycles after start with data 10'h2A5 -> conv_start every 833 cycles with conv_ch=0; audio_out=10'h2A5; audio_valid pulses 1 cycle after conv_done; overrun stays 0.
- Pot scheduling: POT_DIV=4, CHANNELS=2, pot data 10'h100/10'h200 -> a pot conversion follows every 4th audio completion, alternating conv_ch 1, 2; pot_out = {10'h200, 10'h100}; pot_valid pulses 01 then 10.
- Priority collision: audio tick arrives while pot_pend=1 and the engine is idle -> audio issued first; pot issued after the audio conv_done returns the FSM to IDLE.
- Overrun: model never asserts conv_done and holds conv_busy=1 across 2 ticks -> overrun=1 after the second tick; clr_err pulse -> 0; clr_err coincident with a new overrun -> stays 1.
- Timeout: CONV_TIMEOUT=100, no conv_done -> timeout_err=1 after 100 WAIT cycles; no audio_valid; next tick issues a new conversion normally.
- Enable/reset: drop enable mid-WAIT -> that conversion still strobes and no further conv_start occurs; assert reset_n=0 mid-WAIT -> all outputs 0 immediately and a late conv_done is ignored.
